// File: rtl/flag_br_unit_pkg.sv
// Shared definitions for the EX-stage flag/branch unit.
package flag_br_unit_pkg;

  // Bit positions of the architectural flags within {z,v,n}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Branch condition codes carried by the EX-stage branch instruction.
  typedef enum logic [2:0] {
    CC_NEQ    = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cond_code_e;

  // Evaluates a condition code against a {z,v,n} flag vector.
  function automatic logic condEval(input logic [2:0] cc, input logic [2:0] f);
    logic res;
    res = 1'b0;
    case (cond_code_e'(cc))
      CC_NEQ:    res = ~f[FLAG_Z];
      CC_EQ:     res = f[FLAG_Z];
      CC_GT:     res = ~f[FLAG_Z] & ~f[FLAG_N];
      CC_LT:     res = f[FLAG_N];
      CC_GTE:    res = ~f[FLAG_N];
      CC_LTE:    res = f[FLAG_N] | f[FLAG_Z];
      CC_OVFL:   res = f[FLAG_V];
      CC_UNCOND: res = 1'b1;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_br_unit_flag_stack.sv
// Small parameterized LIFO used to save flags across interrupts.
// Pushes win over pops; push when full and pop when empty are ignored.
module flag_stack
  import flag_br_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cntM1;
  logic [PW-1:0] topIdx;
  logic [PW-1:0] wrIdx;
  logic          doPush;
  logic          doPop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~push_i & ~empty_o;
  assign cntM1   = cnt_q - CW'(1);
  assign topIdx  = cntM1[PW-1:0];
  assign wrIdx   = cnt_q[PW-1:0];
  assign data_o  = empty_o ? '0 : mem_q[topIdx];
  assign count_o = cnt_q;

  // Entry storage and occupancy count; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doPush) begin
      mem_q[wrIdx] <= data_i;
      cnt_q        <= cnt_q + CW'(1);
    end else if (doPop) begin
      cnt_q <= cntM1;
    end
  end

endmodule

// File: rtl/flag_br_unit.sv
// EX-stage flag register, branch condition evaluation and interrupt
// flag save/restore with sticky stack error status.
module flag_br_unit
  import flag_br_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         zr,
  input  logic                         ov,
  input  logic                         neg,
  input  logic [2:0]                   upd,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         is_br,
  input  logic [2:0]                   br_cond,
  input  logic                         int_entry,
  input  logic                         reti,
  input  logic                         clr_err,
  output logic [2:0]                   flags,
  output logic                         br_taken,
  output logic [$clog2(STACK_DEPTH):0] stk_cnt,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  logic [2:0] flags_q, flags_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic [2:0] aluFlags;
  logic [2:0] updFlags;
  logic [2:0] stkTop;
  logic       wr;
  logic       pushReq;
  logic       popReq;
  logic       stkFull;
  logic       stkEmpty;

  assign wr       = ~stall & ~flush;
  assign aluFlags = {zr, ov, neg};
  assign pushReq  = int_entry & ~stall;
  assign popReq   = reti & ~stall & ~flush & ~pushReq;

  // The stack gets the next-state flags so a push captures this cycle's update.
  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (3)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .data_i  (updFlags),
    .data_o  (stkTop),
    .count_o (stk_cnt),
    .full_o  (stkFull),
    .empty_o (stkEmpty)
  );

  // Next-state flags and sticky errors; a successful pop overrides the ALU update.
  always_comb begin
    updFlags = flags_q;
    if (wr) begin
      updFlags = (upd & aluFlags) | (~upd & flags_q);
    end
    flags_d = (popReq & ~stkEmpty) ? stkTop : updFlags;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (pushReq & stkFull) begin
      ovf_d = 1'b1;
    end
    if (popReq & stkEmpty) begin
      unf_d = 1'b1;
    end
  end

  // Architectural flag register and sticky error bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign flags    = flags_q;
  assign stk_ovf  = ovf_q;
  assign stk_unf  = unf_q;
  assign br_taken = is_br & ~flush & condEval(br_cond, flags_q);

endmodule

// File: tb/tb_flag_br_unit.sv
// Directed self-checking bench for flag_br_unit.
module tb_flag_br_unit;

  logic       clk;
  logic       rst_n;
  logic       zr, ov, neg;
  logic [2:0] upd;
  logic       stall, flush, is_br;
  logic [2:0] br_cond;
  logic       int_entry, reti, clr_err;
  logic [2:0] flags;
  logic       br_taken;
  logic [2:0] stk_cnt;
  logic       stk_ovf, stk_unf;

  int totalChecks = 0;
  int badChecks   = 0;

  flag_br_unit #(.STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .zr        (zr),
    .ov        (ov),
    .neg       (neg),
    .upd       (upd),
    .stall     (stall),
    .flush     (flush),
    .is_br     (is_br),
    .br_cond   (br_cond),
    .int_entry (int_entry),
    .reti      (reti),
    .clr_err   (clr_err),
    .flags     (flags),
    .br_taken  (br_taken),
    .stk_cnt   (stk_cnt),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts a comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns all control inputs to their idle values.
  task automatic idle();
    zr = 0; ov = 0; neg = 0; upd = 3'b000;
    stall = 0; flush = 0; is_br = 0; br_cond = 3'b000;
    int_entry = 0; reti = 0; clr_err = 0;
  endtask

  // Presents ALU flags with their write enables.
  task automatic applyStimulus(input logic [2:0] u, input logic [2:0] f);
    upd = u; zr = f[2]; ov = f[1]; neg = f[0];
  endtask

  // Advances one clock edge and settles just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] pushVals [5];
    pushVals[0] = 3'b001; pushVals[1] = 3'b010; pushVals[2] = 3'b011;
    pushVals[3] = 3'b100; pushVals[4] = 3'b101;

    idle();
    rst_n = 1'b0;
    #3;
    checkOutput("rst_flags", flags, 3'b000);
    checkOutput("rst_cnt", stk_cnt, 3'd0);
    checkOutput("rst_ovf", stk_ovf, 1'b0);
    checkOutput("rst_unf", stk_unf, 1'b0);
    #9 rst_n = 1'b1;
    tick();

    // Branches against reset flags.
    is_br = 1; br_cond = 3'b001; #1;
    checkOutput("rst_br_eq", br_taken, 1'b0);
    br_cond = 3'b000; #1;
    checkOutput("rst_br_neq", br_taken, 1'b1);
    idle();

    // ADD 5-5 then EQ branch.
    applyStimulus(3'b111, 3'b100);
    tick(); idle();
    checkOutput("add_flags", flags, 3'b100);
    is_br = 1; br_cond = 3'b001; #1;
    checkOutput("add_br_eq", br_taken, 1'b1);
    idle();

    // Shift only writes z and n.
    applyStimulus(3'b111, 3'b111);
    tick();
    checkOutput("all_set", flags, 3'b111);
    applyStimulus(3'b101, 3'b000);
    tick(); idle();
    checkOutput("shift_flags", flags, 3'b010);
    is_br = 1; br_cond = 3'b110; #1;
    checkOutput("br_ovfl", br_taken, 1'b1);
    br_cond = 3'b010; #1;
    checkOutput("br_gt", br_taken, 1'b1);
    br_cond = 3'b011; #1;
    checkOutput("br_lt", br_taken, 1'b0);
    br_cond = 3'b101; #1;
    checkOutput("br_lte", br_taken, 1'b0);
    idle();

    // Stall and flush block the update.
    applyStimulus(3'b111, 3'b101); stall = 1;
    tick();
    checkOutput("stall_hold", flags, 3'b010);
    stall = 0; flush = 1;
    tick(); idle();
    checkOutput("flush_hold", flags, 3'b010);
    is_br = 1; br_cond = 3'b111; flush = 1; #1;
    checkOutput("br_flush", br_taken, 1'b0);
    flush = 0; #1;
    checkOutput("br_uncond", br_taken, 1'b1);
    idle();

    // Push captures the same-cycle update, reti restores it.
    applyStimulus(3'b111, 3'b001);
    tick();
    checkOutput("pre_push", flags, 3'b001);
    applyStimulus(3'b111, 3'b100); int_entry = 1;
    tick(); idle();
    checkOutput("push_flags", flags, 3'b100);
    checkOutput("push_cnt", stk_cnt, 3'd1);
    applyStimulus(3'b111, 3'b111);
    tick(); idle();
    checkOutput("clobber", flags, 3'b111);
    reti = 1;
    tick(); idle();
    checkOutput("reti_flags", flags, 3'b100);
    checkOutput("reti_cnt", stk_cnt, 3'd0);

    // Five pushes into a depth-4 stack.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b111, pushVals[i]); int_entry = 1;
      tick();
    end
    idle();
    checkOutput("full_cnt", stk_cnt, 3'd4);
    checkOutput("full_ovf", stk_ovf, 1'b1);
    checkOutput("ovf_flag_upd", flags, 3'b101);
    for (int i = 3; i >= 0; i--) begin
      reti = 1;
      tick();
      checkOutput($sformatf("pop%0d", i), flags, pushVals[i]);
    end
    checkOutput("empty_cnt", stk_cnt, 3'd0);
    checkOutput("pre_unf", stk_unf, 1'b0);
    reti = 1; clr_err = 1;
    tick(); idle();
    checkOutput("unf_flags", flags, 3'b001);
    checkOutput("unf_set", stk_unf, 1'b1);
    checkOutput("unf_cnt", stk_cnt, 3'd0);
    checkOutput("clr_ovf_only", stk_ovf, 1'b0);
    clr_err = 1;
    tick(); idle();
    checkOutput("clr_unf", stk_unf, 1'b0);
    checkOutput("clr_ovf", stk_ovf, 1'b0);

    // Simultaneous push and pop: push wins.
    applyStimulus(3'b111, 3'b110); int_entry = 1; tick();
    applyStimulus(3'b111, 3'b011); int_entry = 1; tick();
    idle();
    checkOutput("two_cnt", stk_cnt, 3'd2);
    applyStimulus(3'b111, 3'b000); int_entry = 1; reti = 1;
    tick(); idle();
    checkOutput("both_cnt", stk_cnt, 3'd3);
    checkOutput("both_flags", flags, 3'b000);
    checkOutput("both_unf", stk_unf, 1'b0);
    reti = 1; tick();
    checkOutput("pop_a", flags, 3'b000);
    tick(); idle();
    checkOutput("pop_b", flags, 3'b011);
    checkOutput("pop_b_cnt", stk_cnt, 3'd1);

    // Asynchronous reset mid-sequence.
    applyStimulus(3'b111, 3'b100); tick(); idle();
    checkOutput("pre_rst", flags, 3'b100);
    #2 rst_n = 1'b0; #1;
    is_br = 1; br_cond = 3'b001; #1;
    checkOutput("mid_rst_flags", flags, 3'b000);
    checkOutput("mid_rst_cnt", stk_cnt, 3'd0);
    checkOutput("mid_rst_br", br_taken, 1'b0);
    idle();
    #3 rst_n = 1'b1;
    reti = 1; tick(); idle();
    checkOutput("post_rst_unf", stk_unf, 1'b1);
    checkOutput("post_rst_flags", flags, 3'b000);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/flag_br_unit.md
# flag_br_unit

Consumer end of the EX-stage ALU flag interface: captures the ALU's `zr`/`ov`/`neg` outputs into an architectural flag register under per-flag write enables, evaluates branch conditions against that register, and saves/restores flags across interrupt entry and return through a small LIFO. Sits in EX beside the ALU. Feeds `br_taken` to PC-select logic and flag-stack error status to the interrupt controller.

## Interface

- `STACK_DEPTH`, 4: flag-stack entries; power of two, ≥2.
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `zr`, `ov`, `neg` input 1 each: ALU flags for the instruction in EX (combinational, same cycle).
- `upd` input 3: per-flag write enables `{z,v,n}` from decode for the EX instruction. ADD/SUB drive 111; AND/NOR/shift drive 101; LHB and others drive 000.
- `stall` input 1: EX held this cycle.
- `flush` input 1: EX instruction killed this cycle.
- `is_br` input 1: EX instruction is a conditional branch.
- `br_cond` input 3: condition code of the EX branch.
- `int_entry` input 1: interrupt entry; push flags.
- `reti` input 1: return from interrupt; pop flags.
- `clr_err` input 1: clear sticky error bits.
- `flags` output 3: registered `{z,v,n}`.
- `br_taken` output 1: combinational branch decision.
- `stk_cnt` output $clog2(STACK_DEPTH)+1: occupied entries.
- `stk_ovf`, `stk_unf` output 1 each: sticky push-when-full and pop-when-empty errors.

## Operation

- Update qualifier: `wr = ~stall & ~flush`. When `wr`, each flag bit with its `upd` bit set loads the ALU input; other bits hold.
- Condition codes: 000 NEQ = ~z; 001 EQ = z; 010 GT = ~z & ~n; 011 LT = n; 100 GTE = ~n; 101 LTE = n | z; 110 OVFL = v; 111 UNCOND = 1.
- `n` is valid after saturation because the ALU derives it from the saturated result.
- `br_taken = is_br & ~flush & cond(br_cond, flags)`. It uses the registered flags only. The instruction preceding a branch has already written `flags` by the time the branch reaches EX, so no forwarding path exists.
- Push (`int_entry & ~stall`):
  - Stores the next-state flags, i.e. including this cycle's `wr` update.
  - `stk_cnt` increments.
  - If `stk_cnt == STACK_DEPTH`: stack and count are unchanged and `stk_ovf` sets. The flag update still occurs.
  - Push is not gated by `flush`.
- Pop (`reti & ~stall & ~flush`):
  - `flags` loads the top entry and `stk_cnt` decrements.
  - The popped value overrides any same-cycle `wr` update.
  - If `stk_cnt == 0`: `flags` keeps the normal update path, count stays 0, and `stk_unf` sets.
- Push and pop in the same cycle: push wins and pop is ignored. No error is flagged for the ignored pop.
- `clr_err` clears `stk_ovf`/`stk_unf`. A same-cycle error event wins, so the bit stays set.

## Timing

- Reset (async assert, sync-safe deassert): `flags` = 000, `stk_cnt` = 0, `stk_ovf` = `stk_unf` = 0, all stack entries 0. `br_taken` follows its inputs with `flags` = 000.
- Flag write latency: 1 cycle. A value sampled at edge k is visible on `flags` and used by a branch in EX during cycle k+1.
- Push/pop take effect at the same edge. Popped flags are visible the next cycle.
- `br_taken` has zero latency (combinational from `flags`, `is_br`, `br_cond`, `flush`).
- While `stall` is high, all state holds. Controllers must keep `int_entry`/`reti` asserted until the stall drops.
- Reset mid-operation discards the stack contents.

## Structure

- Add condition-code localparams (NEQ…UNCOND) and flag bit indices (Z=2, V=1, N=0) to `common_params.inc`.
- Sub-module `flag_stack`:
  - Parameterized LIFO with push, pop, data in/out, count, full, empty.
  - The top entry is readable combinationally.
- The top level holds the flag register, condition evaluation, priority logic and sticky errors.

## Test plan

- Reset, then branch EQ → `br_taken` = 0. ADD 5−5 (`zr`=1, `upd`=111), then EQ branch next cycle → `br_taken` = 1, `flags` = 100.
- `flags` = 111, shift with `upd`=101, `zr`=0, `ov`=0, `neg`=0 → `flags` = 010 (v held). OVFL branch → taken.
- Flag update with `stall`=1, then with `flush`=1 → `flags` unchanged both cycles. Branch with `flush`=1 and UNCOND → `br_taken` = 0.
- Push `flags`=001 same cycle as SUB producing `zr`=1, `neg`=0 → stacked 100. Clobber flags, `reti` → `flags` = 100, `stk_cnt` = 0.
- 5 pushes with depth 4 → `stk_cnt` = 4, `stk_ovf` = 1. 4 pops return LIFO order. 5th pop → `stk_unf` = 1, `flags` unchanged. `clr_err` → both 0.
- `int_entry` and `reti` together with `stk_cnt`=2 → `stk_cnt` = 3, flags not restored. Assert `rst_n`=0 mid-sequence → all outputs return to reset values immediately.
